// File: rtl/ras_ctrl_pkg.sv
// Shared ISA constants, state encodings and
// call/return classification for the RAS controller.
package ras_ctrl_pkg;

    localparam int XLEN           = 32;
    localparam int RAS_SIZE       = 8;
    localparam int RAS_PTR_WIDTH  = $clog2(RAS_SIZE);
    localparam int RAS_CKPT_DEPTH = 4;

    localparam logic [6:0] OP_J_JAL  = 7'b1101111;
    localparam logic [6:0] OP_J_JALR = 7'b1100111;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_POP2PUSH = 2'd1,
        ST_RECOVER  = 2'd2
    } ras_state_e;

    typedef enum logic [1:0] {
        RC_NONE,
        RC_CALL,
        RC_RET,
        RC_CORO
    } ras_cls_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

    // JALR with rd == rs1 == link is a plain call, not a swap
    function automatic ras_cls_e classify(
        input logic [6:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1
    );
        logic     lrd;
        logic     lrs;
        logic     jalr;
        logic     swap;
        ras_cls_e c;
        lrd  = is_link(rd);
        lrs  = is_link(rs1);
        jalr = (op == OP_J_JALR);
        swap = lrd && lrs && (rd != rs1);
        c    = RC_NONE;
        unique case (1'b1)
            (op == OP_J_JAL) && lrd: c = RC_CALL;
            jalr && swap:            c = RC_CORO;
            jalr && lrd && !swap:    c = RC_CALL;
            jalr && !lrd && lrs:     c = RC_RET;
            default:                 c = RC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// Request, stack-command and resolve signals
// between the decode stage and the RAS controller.
interface ras_ctrl_if
    import ras_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = RAS_CKPT_DEPTH
);
    localparam int CW = $clog2(CKPT_DEPTH + 1);

    logic                     req_valid;
    logic                     req_ready;
    logic [6:0]               req_opcode;
    logic [4:0]               req_rd;
    logic [4:0]               req_rs1;
    logic [XLEN-1:0]          req_ret_addr;
    logic [RAS_PTR_WIDTH-1:0] ras_ptr;
    logic                     ras_valid;
    logic                     ras_push;
    logic                     ras_pop;
    logic [XLEN-1:0]          ras_push_addr;
    logic                     ras_restore;
    logic [RAS_PTR_WIDTH-1:0] ras_restore_ptr;
    logic                     pred_use_ras;
    logic                     resolve_valid;
    logic                     resolve_mispredict;
    logic                     flush;
    logic [CW-1:0]            ckpt_count;
    logic                     err_underflow;

    modport master (
        output req_valid, req_opcode, req_rd, req_rs1,
        output req_ret_addr, ras_ptr, ras_valid,
        output resolve_valid, resolve_mispredict, flush,
        input  req_ready, ras_push, ras_pop, ras_push_addr,
        input  ras_restore, ras_restore_ptr, pred_use_ras,
        input  ckpt_count, err_underflow
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_rs1,
        input  req_ret_addr, ras_ptr, ras_valid,
        input  resolve_valid, resolve_mispredict, flush,
        output req_ready, ras_push, ras_pop, ras_push_addr,
        output ras_restore, ras_restore_ptr, pred_use_ras,
        output ckpt_count, err_underflow
    );

endinterface

// File: rtl/ras_ckpt_fifo.sv
// Circular queue of RAS pointer checkpoints,
// oldest at head; clear wins over enq/deq.
module ras_ckpt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_i,
    input  logic [W-1:0]               enq_data_i,
    input  logic                       deq_i,
    input  logic                       clear_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (enq_i && !clear_i) begin
            mem_q[wr_q] <= enq_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq_i) wr_q <= wr_q + 1'b1;
            if (deq_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(enq_i) - CW'(deq_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: classifies calls/returns,
// drives stack commands and checkpoints the stack pointer.
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter int CKPT_DEPTH = RAS_CKPT_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    ras_ctrl_if.slave bus
);
    localparam int CW = $clog2(CKPT_DEPTH + 1);
    localparam int PW = RAS_PTR_WIDTH;

    ras_state_e      state_q;
    logic [XLEN-1:0] coro_addr_q;
    logic [PW-1:0]   restore_ptr_q;
    logic            err_q;

    ras_cls_e        cls;
    logic [PW-1:0]   head;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            kill;
    logic            deq_ok;
    logic            ready;
    logic            fire;
    logic            recover;

    assign cls = classify(bus.req_opcode, bus.req_rd,
                          bus.req_rs1);

    assign empty   = (count == '0);
    assign full    = (count == CW'(CKPT_DEPTH));
    assign kill    = bus.flush ||
                     (bus.resolve_valid && bus.resolve_mispredict);
    assign deq_ok  = bus.resolve_valid &&
                     !bus.resolve_mispredict && !empty;
    assign recover = kill && !empty;

    // A same-cycle dequeue frees a slot even when full
    always_comb begin
        ready = 1'b0;
        if (state_q == ST_ACTIVE && !kill) begin
            ready = (cls == RC_NONE) || !full || deq_ok;
        end
    end

    assign fire = bus.req_valid && ready;

    always_comb begin
        bus.ras_push        = 1'b0;
        bus.ras_pop         = 1'b0;
        bus.ras_push_addr   = '0;
        bus.pred_use_ras    = 1'b0;
        bus.ras_restore     = 1'b0;
        bus.ras_restore_ptr = '0;
        unique case (state_q)
            ST_ACTIVE: begin
                if (fire) begin
                    unique case (cls)
                        RC_CALL: begin
                            bus.ras_push      = 1'b1;
                            bus.ras_push_addr = bus.req_ret_addr;
                        end
                        RC_RET: begin
                            bus.ras_pop      = bus.ras_valid;
                            bus.pred_use_ras = bus.ras_valid;
                        end
                        RC_CORO: bus.ras_pop = bus.ras_valid;
                        default: ;
                    endcase
                end
            end
            ST_POP2PUSH: begin
                bus.ras_push      = !kill;
                bus.ras_push_addr = kill ? '0 : coro_addr_q;
            end
            ST_RECOVER: begin
                bus.ras_restore     = 1'b1;
                bus.ras_restore_ptr = restore_ptr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACTIVE;
            coro_addr_q   <= '0;
            restore_ptr_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (bus.resolve_valid && empty) err_q <= 1'b1;
            if (recover) begin
                state_q       <= ST_RECOVER;
                restore_ptr_q <= head;
            end else if (kill) begin
                state_q <= ST_ACTIVE;
            end else begin
                unique case (state_q)
                    ST_ACTIVE: begin
                        if (fire && cls == RC_CORO) begin
                            state_q     <= ST_POP2PUSH;
                            coro_addr_q <= bus.req_ret_addr;
                        end
                    end
                    default: state_q <= ST_ACTIVE;
                endcase
            end
        end
    end

    ras_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq_i      (fire && cls != RC_NONE),
        .enq_data_i (bus.ras_ptr),
        .deq_i      (deq_ok),
        .clear_i    (kill),
        .head_o     (head),
        .count_o    (count)
    );

    assign bus.req_ready     = ready;
    assign bus.ckpt_count    = count;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed and random checks of ras_ctrl against
// a queue-based model of the checkpoint rules.
module tb_ras_ctrl;
    import ras_ctrl_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ras_ctrl_if #(.CKPT_DEPTH(D)) b ();

    ras_ctrl #(.CKPT_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int          m_q[$];
    int          m_phase = 0;
    logic [31:0] m_pend = '0;
    bit          m_err = 1'b0;
    int          m_rptr = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    // 0 none, 1 call, 2 return, 3 coroutine swap
    function automatic int kind_of(input logic [6:0] op,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs1);
        bit lrd = (rd == 5'd1) || (rd == 5'd5);
        bit lrs = (rs1 == 5'd1) || (rs1 == 5'd5);
        if (op == 7'b1101111) return lrd ? 1 : 0;
        if (op != 7'b1100111) return 0;
        if (lrd && lrs && rd != rs1) return 3;
        if (lrd) return 1;
        if (lrs) return 2;
        return 0;
    endfunction

    task automatic drive(input bit v, input logic [6:0] op,
                         input logic [4:0] rd,
                         input logic [4:0] rs1,
                         input logic [31:0] ret,
                         input logic [2:0] ptr, input bit rv,
                         input bit res, input bit mis,
                         input bit fl);
        b.req_valid          = v;
        b.req_opcode         = op;
        b.req_rd             = rd;
        b.req_rs1            = rs1;
        b.req_ret_addr       = ret;
        b.ras_ptr            = ptr;
        b.ras_valid          = rv;
        b.resolve_valid      = res;
        b.resolve_mispredict = mis;
        b.flush              = fl;
    endtask

    task automatic idle();
        drive(0, 7'h13, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle(input bit check);
        int k;
        bit kill, deqok, rdy, fire, e_push, e_pop, e_pred;
        logic [31:0] e_addr;
        #1;
        k = kind_of(b.req_opcode, b.req_rd, b.req_rs1);
        kill = b.flush ||
               (b.resolve_valid && b.resolve_mispredict);
        deqok = b.resolve_valid && !b.resolve_mispredict &&
                m_q.size() > 0;
        rdy = (m_phase == 0) && !kill &&
              (k == 0 || m_q.size() < D || deqok);
        fire = b.req_valid && rdy;
        e_push = (m_phase == 0 && fire && k == 1) ||
                 (m_phase == 1 && !kill);
        e_addr = (m_phase == 1) ? m_pend : b.req_ret_addr;
        e_pop = (m_phase == 0) && fire &&
                (k == 2 || k == 3) && b.ras_valid;
        e_pred = fire && k == 2 && b.ras_valid;
        if (check && !reset) begin
            chk("req_ready", 32'(b.req_ready), 32'(rdy));
            chk("ras_push", 32'(b.ras_push), 32'(e_push));
            chk("ras_pop", 32'(b.ras_pop), 32'(e_pop));
            chk("pred_use_ras", 32'(b.pred_use_ras),
                32'(e_pred));
            chk("ras_restore", 32'(b.ras_restore),
                32'(m_phase == 2));
            chk("ckpt_count", 32'(b.ckpt_count),
                32'(m_q.size()));
            chk("err_underflow", 32'(b.err_underflow),
                32'(m_err));
            if (e_push)
                chk("push_addr", b.ras_push_addr, e_addr);
            if (m_phase == 2)
                chk("restore_ptr", 32'(b.ras_restore_ptr),
                    32'(m_rptr));
        end
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_err = 1'b0;
            m_pend = '0;
        end else begin
            if (b.resolve_valid && m_q.size() == 0)
                m_err = 1'b1;
            if (kill) begin
                if (m_q.size() > 0) begin
                    m_rptr = m_q[0];
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
                m_q.delete();
            end else begin
                if (deqok) void'(m_q.pop_front());
                if (fire && k != 0) m_q.push_back(int'(b.ras_ptr));
                if (m_phase != 0) begin
                    m_phase = 0;
                end else if (fire && k == 3) begin
                    m_phase = 1;
                    m_pend = b.req_ret_addr;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle(0);
        cycle(0);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        cycle(1);

        // single call
        drive(1, OP_J_JAL, 1, 0, 32'h104, 0, 0, 0, 0, 0);
        cycle(1);
        idle();
        chk("call_count", 32'(b.ckpt_count), 1);
        cycle(1);

        // fill, stall, then accept on a same-cycle resolve
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_J_JAL, 5, 0, 32'h300 + 32'(4 * i),
                  3'(i), 0, 0, 0, 0);
            cycle(1);
        end
        drive(1, OP_J_JAL, 1, 0, 32'h400, 4, 0, 0, 0, 0);
        cycle(1);
        drive(1, OP_J_JAL, 1, 0, 32'h400, 4, 0, 1, 0, 0);
        cycle(1);
        idle();
        chk("full_count", 32'(b.ckpt_count), 4);
        cycle(1);
        drive(0, 7'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1);
        idle();
        cycle(1);
        cycle(1);

        // return with empty stack
        drive(1, OP_J_JALR, 0, 1, 32'h500, 6, 0, 0, 0, 0);
        cycle(1);
        idle();
        cycle(1);

        // coroutine swap; next cycle must stall and push
        drive(1, OP_J_JALR, 1, 5, 32'h200, 5, 1, 0, 0, 0);
        cycle(1);
        drive(1, OP_J_JAL, 1, 0, 32'h600, 4, 1, 0, 0, 0);
        cycle(1);
        idle();
        cycle(1);

        // mispredict rolls back to oldest checkpoint
        do_reset();
        for (int i = 2; i <= 4; i++) begin
            drive(1, OP_J_JAL, 1, 0, 32'h700, 3'(i),
                  0, 0, 0, 0);
            cycle(1);
        end
        drive(0, 7'h13, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(1);
        drive(1, OP_J_JAL, 1, 0, 32'h800, 1, 0, 0, 0, 0);
        #1;
        chk("mis_restore", 32'(b.ras_restore), 1);
        chk("mis_ptr", 32'(b.ras_restore_ptr), 2);
        cycle(1);
        idle();
        cycle(1);

        // reset in the middle of a pending swap push
        drive(1, OP_J_JALR, 5, 1, 32'h900, 3, 1, 0, 0, 0);
        cycle(1);
        do_reset();
        cycle(1);

        // underflow is sticky until reset
        drive(0, 7'h13, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1);
        idle();
        for (int i = 0; i < 3; i++) cycle(1);
        chk("uflow_held", 32'(b.err_underflow), 1);
        do_reset();
        cycle(1);

        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            logic [4:0] rd, rs1;
            bit res;
            case ($urandom_range(0, 3))
                0:       op = OP_J_JAL;
                1, 2:    op = OP_J_JALR;
                default: op = 7'h13;
            endcase
            case ($urandom_range(0, 3))
                0:       rd = 5'd0;
                1:       rd = 5'd1;
                2:       rd = 5'd5;
                default: rd = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 3))
                0:       rs1 = 5'd0;
                1:       rs1 = 5'd1;
                2:       rs1 = 5'd5;
                default: rs1 = 5'($urandom_range(0, 31));
            endcase
            res = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, op, rd, rs1,
                  $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), res,
                  res && ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 31) == 0);
            if (n == 300) reset = 1'b1;
            if (n == 302) reset = 1'b0;
            cycle(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
